// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Reusable pipeline stage register. Holds one payload/control entry in a main
// register (M) that drives the outputs directly, plus one entry in a skid
// register (S). S absorbs the entry that upstream commits in the same cycle
// the downstream stalls. This keeps in_ready purely registered (apart from
// flush/reset), so it carries no combinational path from out_ready.
//
// A flush squashes both entries and turns the stage into a bubble whose
// control bundle is BUBBLE_CTRL. A saturating counter records how many cycles
// the stage sat on a valid entry that downstream would not take.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   flush      synchronous squash of all held entries
//   in_valid   upstream offers an entry
//   in_ready   stage can accept an entry this cycle
//   in_data    upstream payload (DATA_W)
//   in_ctrl    upstream control bundle (CTRL_W)
//   out_valid  main register holds a valid entry
//   out_ready  downstream consumes the entry this cycle
//   out_data   main register payload (DATA_W)
//   out_ctrl   main register control, BUBBLE_CTRL whenever out_valid=0
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic [CTRL_W-1:0] m_ctrl;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic [CTRL_W-1:0] s_ctrl;
    logic [CNT_W-1:0]  stall_q;

    logic in_fire;
    logic m_free;
    logic stalled;

    // The stage accepts only while the skid slot is empty. Flush and reset
    // also refuse input so that nothing sneaks in behind a squash.
    assign in_ready = ~s_valid & ~flush & ~reset;
    assign in_fire  = in_valid & in_ready;

    // M can take a new entry when it is empty or its entry leaves this cycle.
    assign m_free   = ~m_valid | out_ready;
    assign stalled  = m_valid & ~out_ready;

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign out_ctrl  = m_ctrl;
    assign stall_cnt = stall_q;

    // Main/skid register update. S always holds an entry older than anything
    // still upstream, so when M frees up it refills from S first. When S is
    // full in_ready is already low, so no new entry can arrive in that case.
    // Every path that clears m_valid also loads BUBBLE_CTRL, which keeps
    // out_ctrl safe while the stage is empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= BUBBLE_CTRL;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= BUBBLE_CTRL;
        end else if (flush) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_ctrl  <= BUBBLE_CTRL;
            s_valid <= 1'b0;
            s_data  <= '0;
            s_ctrl  <= BUBBLE_CTRL;
        end else if (m_free) begin
            if (s_valid) begin
                m_valid <= 1'b1;
                m_data  <= s_data;
                m_ctrl  <= s_ctrl;
                if (in_fire) begin
                    s_valid <= 1'b1;
                    s_data  <= in_data;
                    s_ctrl  <= in_ctrl;
                end else begin
                    s_valid <= 1'b0;
                    s_ctrl  <= BUBBLE_CTRL;
                end
            end else if (in_fire) begin
                m_valid <= 1'b1;
                m_data  <= in_data;
                m_ctrl  <= in_ctrl;
            end else begin
                m_valid <= 1'b0;
                m_ctrl  <= BUBBLE_CTRL;
            end
        end else if (in_fire) begin
            s_valid <= 1'b1;
            s_data  <= in_data;
            s_ctrl  <= in_ctrl;
        end
    end

    // Stall counter: cleared by reset only; a flush leaves it untouched so
    // debug history survives mispredicts. Saturates instead of wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (!flush && stalled && (stall_q != CNT_MAX)) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    // A skid entry can only exist behind a valid main entry; an empty stage
    // must present the bubble control value.
    a_skid_implies_main : assert property (@(posedge clk) disable iff (reset)
        s_valid |-> m_valid);

    a_bubble_ctrl : assert property (@(posedge clk) disable iff (reset)
        !m_valid |-> (m_ctrl == BUBBLE_CTRL));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed testbench for pipe_stage_reg. Instance "dut" uses the default
// widths with a non-zero bubble control value; instance "dutSat" uses a 3-bit
// stall counter to exercise saturation. Expected values are hand-computed in
// the stimulus sequence below.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam int          DW  = 96;
    localparam int          CW  = 16;
    localparam logic [15:0] BUB = 16'h0F00;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   stall_cnt;

    logic          sat_reset;
    logic          sat_flush;
    logic          sat_in_valid;
    logic          sat_in_ready;
    logic [7:0]    sat_in_data;
    logic [3:0]    sat_in_ctrl;
    logic          sat_out_valid;
    logic          sat_out_ready;
    logic [7:0]    sat_out_data;
    logic [3:0]    sat_out_ctrl;
    logic [2:0]    sat_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .DATA_W(DW), .CTRL_W(CW), .BUBBLE_CTRL(BUB), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(
        .DATA_W(8), .CTRL_W(4), .BUBBLE_CTRL(4'h0), .CNT_W(3)
    ) dutSat (
        .clk(clk), .reset(sat_reset), .flush(sat_flush),
        .in_valid(sat_in_valid), .in_ready(sat_in_ready),
        .in_data(sat_in_data), .in_ctrl(sat_in_ctrl),
        .out_valid(sat_out_valid), .out_ready(sat_out_ready),
        .out_data(sat_out_data), .out_ctrl(sat_out_ctrl),
        .stall_cnt(sat_stall_cnt)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Advance to just after the next rising edge so outputs are settled.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic [CW-1:0] c, input logic rdy);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = rdy;
    endtask

    function automatic logic [CW-1:0] ctrlOf(input logic [DW-1:0] d);
        return 16'h1000 | CW'(d[7:0]);
    endfunction

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b0);
        sat_reset     = 1'b1;
        sat_flush     = 1'b0;
        sat_in_valid  = 1'b0;
        sat_in_data   = '0;
        sat_in_ctrl   = '0;
        sat_out_ready = 1'b0;

        // Reset state, then idle
        tick;
        checkOutput("ready_in_reset", in_ready, 1'b0);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_ctrl", out_ctrl, BUB);
        checkOutput("rst_stall", stall_cnt, 16'd0);
        reset = 1'b0;
        #1;
        checkOutput("idle_ready", in_ready, 1'b1);

        // Streaming 1..8 with out_ready high: one-cycle latency, no gaps
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, DW'(i), ctrlOf(DW'(i)), 1'b1);
            tick;
            checkOutput($sformatf("str_valid%0d", i), out_valid, 1'b1);
            checkOutput($sformatf("str_data%0d", i), out_data, DW'(i));
            checkOutput($sformatf("str_ctrl%0d", i), out_ctrl, ctrlOf(DW'(i)));
            checkOutput($sformatf("str_ready%0d", i), in_ready, 1'b1);
        end
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick;
        checkOutput("str_drain_valid", out_valid, 1'b0);
        checkOutput("str_drain_ctrl", out_ctrl, BUB);
        checkOutput("str_stall", stall_cnt, 16'd0);

        // Back-pressure: A, B, C with out_ready low for 3 cycles
        applyStimulus(1'b1, 96'hA, ctrlOf(96'hA), 1'b1);
        tick;
        checkOutput("bp_a_data", out_data, 96'hA);
        applyStimulus(1'b1, 96'hB, ctrlOf(96'hB), 1'b0);
        tick;
        checkOutput("bp_b_skid_ready", in_ready, 1'b0);
        checkOutput("bp_hold_a1", out_data, 96'hA);
        applyStimulus(1'b1, 96'hC, ctrlOf(96'hC), 1'b0);
        tick;
        tick;
        checkOutput("bp_stall3", stall_cnt, 16'd3);
        checkOutput("bp_hold_a3", out_data, 96'hA);
        checkOutput("bp_c_blocked", in_ready, 1'b0);
        applyStimulus(1'b1, 96'hC, ctrlOf(96'hC), 1'b1);
        tick;
        checkOutput("bp_out_b", out_data, 96'hB);
        checkOutput("bp_out_b_ctrl", out_ctrl, ctrlOf(96'hB));
        checkOutput("bp_ready_back", in_ready, 1'b1);
        tick;
        checkOutput("bp_out_c", out_data, 96'hC);
        checkOutput("bp_out_c_valid", out_valid, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick;
        checkOutput("bp_empty", out_valid, 1'b0);
        checkOutput("bp_stall_kept", stall_cnt, 16'd3);

        // Flush with both registers full
        applyStimulus(1'b1, 96'hD, ctrlOf(96'hD), 1'b0);
        tick;
        applyStimulus(1'b1, 96'hE, ctrlOf(96'hE), 1'b0);
        tick;
        checkOutput("fl_full_ready", in_ready, 1'b0);
        checkOutput("fl_pre_stall", stall_cnt, 16'd4);
        flush = 1'b1;
        applyStimulus(1'b1, 96'hF, ctrlOf(96'hF), 1'b0);
        #1;
        checkOutput("fl_ready_low", in_ready, 1'b0);
        tick;
        flush = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("fl_valid", out_valid, 1'b0);
        checkOutput("fl_ctrl", out_ctrl, BUB);
        checkOutput("fl_stall_held", stall_cnt, 16'd4);
        tick;
        checkOutput("fl_f_dropped", out_valid, 1'b0);

        // Simultaneous fire: M=G, S=H, then out_ready=1 with I offered
        applyStimulus(1'b1, 96'h6, ctrlOf(96'h6), 1'b0);
        tick;
        applyStimulus(1'b1, 96'h7, ctrlOf(96'h7), 1'b0);
        tick;
        applyStimulus(1'b1, 96'h9, ctrlOf(96'h9), 1'b1);
        #1;
        checkOutput("sf_ready_low", in_ready, 1'b0);
        tick;
        checkOutput("sf_s_to_m", out_data, 96'h7);
        checkOutput("sf_ready_next", in_ready, 1'b1);
        tick;
        checkOutput("sf_new_in", out_data, 96'h9);
        checkOutput("sf_new_ctrl", out_ctrl, ctrlOf(96'h9));
        checkOutput("sf_stall", stall_cnt, 16'd5);

        // Reset mid-transfer drops the entry; input accepted right after
        applyStimulus(1'b1, 96'h11, ctrlOf(96'h11), 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("mr_ready_low", in_ready, 1'b0);
        tick;
        checkOutput("mr_valid", out_valid, 1'b0);
        checkOutput("mr_stall", stall_cnt, 16'd0);
        checkOutput("mr_ctrl", out_ctrl, BUB);
        reset = 1'b0;
        applyStimulus(1'b1, 96'h12, ctrlOf(96'h12), 1'b1);
        tick;
        checkOutput("mr_first_data", out_data, 96'h12);
        checkOutput("mr_first_valid", out_valid, 1'b1);

        // Counter saturation on the 3-bit instance
        sat_reset    = 1'b0;
        sat_in_valid = 1'b1;
        sat_in_data  = 8'h5A;
        sat_in_ctrl  = 4'h3;
        tick;
        sat_in_valid = 1'b0;
        checkOutput("sat_loaded", sat_out_data, 8'h5A);
        checkOutput("sat_start", sat_stall_cnt, 3'd0);
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (i == 6) checkOutput("sat_six", sat_stall_cnt, 3'd6);
            if (i == 7) checkOutput("sat_seven", sat_stall_cnt, 3'd7);
        end
        checkOutput("sat_hold", sat_stall_cnt, 3'd7);
        checkOutput("sat_still_valid", sat_out_valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
